probe_capture_ctrl: RTL

Trigger-and-capture sequencer for the 32-bit debug probe word `data2` in the FPGA controller. It runs a circular pre-trigger buffer, detects a masked pattern match, collects a programmable number of post-trigger samples and then freezes. Writes go to an external single-port sample RAM, and it reports where the captured window starts. It sits between the probed datapath and the readout logic on the same `clk` domain.

---
 rtl/probe_capture_ctrl_if.sv | 16 +
 rtl/probe_capture_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/probe_capture_ctrl_if.sv
// probe_capture_ctrl_if: write port of the external single-port sample RAM.
//   wr_en    write strobe, one write per clk, no backpressure
//   wr_addr  RAM write address
//   wr_data  sample to store
// master: the capture controller driving the RAM; slave: the RAM or an observer.
interface probe_capture_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/probe_capture_ctrl.sv
// probe_capture_ctrl: trigger-and-capture sequencer for the debug probe word.
// Keeps a circular pre-trigger history in an external RAM, waits for a masked
// pattern match, collects the post-trigger samples and then freezes, reporting
// where the captured window starts.
//   clk, rst        clock and synchronous active-high reset
//   arm, abort      single-cycle control pulses (abort wins over arm)
//   data2           probe sample, one per clk
//   trig_mask/value match when ((data2 ^ trig_value) & trig_mask) == 0
//   post_count      post-trigger samples incl. the trigger sample, latched on arm
//   ram             RAM write port (registered wr_en/wr_addr/wr_data)
//   busy, done      capture in progress / capture complete
//   trig_addr       RAM address of the trigger sample (valid while done)
//   start_addr      RAM address of the oldest sample in the window (valid while done)
module probe_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W:0]   post_count,
  probe_capture_ctrl_if.master ram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [ADDR_W:0] DepthW = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneW   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   post_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [ADDR_W-1:0] start_addr_q;

  logic [ADDR_W:0]   post_eff;
  logic [ADDR_W:0]   pre_eff;
  logic              trig_hit;
  logic [ADDR_W-1:0] ptr_inc;

  always_comb begin
    post_eff = post_count;
    if (post_count == '0) begin
      post_eff = OneW;
    end else if (post_count > DepthW) begin
      post_eff = DepthW;
    end
    pre_eff  = DepthW - post_eff;
    trig_hit = ((data2 ^ trig_value) & trig_mask) == '0;
    ptr_inc  = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      post_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else if (abort) begin
      // The sample of the abort cycle is dropped; earlier writes stand.
      state_q <= StIdle;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q inside {StPre, StWait, StPost}) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= ptr_q;
        wr_data_q <= data2;
        ptr_q     <= ptr_inc;
      end

      case (state_q)
        StIdle, StDone: begin
          // Entering DONE leaves busy up for the cycle carrying the last
          // write strobe; the flags swap one cycle later.
          if (state_q == StDone) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          if (arm) begin
            post_q <= post_eff;
            ptr_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            if (pre_eff != '0) begin
              cnt_q   <= pre_eff;
              state_q <= StPre;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StPre: begin
          cnt_q <= cnt_q - OneW;
          if (cnt_q == OneW) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (trig_hit) begin
            trig_addr_q <= ptr_q;
            if (post_q == OneW) begin
              start_addr_q <= ptr_inc;
              state_q      <= StDone;
            end else begin
              cnt_q   <= post_q - OneW;
              state_q <= StPost;
            end
          end
        end
        StPost: begin
          cnt_q <= cnt_q - OneW;
          if (cnt_q == OneW) begin
            // Pointer after the last write is the oldest sample in the ring.
            start_addr_q <= ptr_inc;
            state_q      <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign trig_addr   = trig_addr_q;
  assign start_addr  = start_addr_q;

endmodule
